// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   - access size codes (SZ_B/SZ_H/SZ_W/SZ_D)
//   - LSU state encoding
//   - size_mask(): right-justified data mask for an access size
//   - low_mask():  byte-address bits that lie below the size boundary
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_t;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic [2:0] low_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for the LSU.
//   Extract: pulls the size-wide field at byte lane 'lane' out of rdata and
//            zero- or sign-extends it to 64 bits (ext_data).
//   Insert:  replaces the size-wide field at 'lane' in rdata with the low
//            bits of wdata (merged), used by the sub-word store RMW path.
// Ports:
//   rdata    in  64  dword read from data_mem
//   lane     in  3   byte lane (addr[2:0], already aligned to size)
//   size     in  2   access size code
//   sext     in  1   sign-extend the extracted field
//   wdata    in  64  right-justified store data
//   ext_data out 64  extracted, extended load value
//   merged   out 64  rdata with the store field inserted
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [63:0] wdata,
  output logic [63:0] ext_data,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] mask;
  logic [63:0] field;
  logic [63:0] lane_mask;
  logic        sign;

  always_comb begin
    shamt = {lane, 3'b000};
    mask  = size_mask(size);
    field = (rdata >> shamt) & mask;
    case (size)
      SZ_B:    sign = field[7];
      SZ_H:    sign = field[15];
      SZ_W:    sign = field[31];
      default: sign = field[63];
    endcase
    ext_data  = (sext && sign) ? (field | ~mask) : field;
    lane_mask = mask << shamt;
    merged    = (rdata & ~lane_mask) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the EX/MEM register and data_mem.
//   Adds byte/half/word/dword loads (optionally sign-extended) and stores on
//   top of a 64-bit dword-indexed memory. Sub-word stores are a 2-cycle
//   read-modify-write that stalls the pipeline for one cycle. Load results
//   are registered (1-cycle latency).
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   - misaligned accesses are rejected and flag err
//   undefined - address bits below the size boundary are forced to 0
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_ld, req_st        load / store request
//   req_size, req_sext    access size code, sign-extend load result
//   req_addr, req_wdata   byte address, right-justified store data
//   mem_rdata             data_mem read data (combinational)
//   MemRead, MemWrite     data_mem strobes
//   mem_addr, mem_wdata   data_mem address / write data
//   stall                 freeze the front of the pipeline this cycle
//   ld_data, ld_valid     registered load result and its 1-cycle valid
//   err                   misalignment or ld+st collision
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter bit          ERR_STICKY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              stall,
  output logic [63:0]       ld_data,
  output logic              ld_valid,
  output logic              err
);

  lsu_state_t        state, state_nx;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] abuf;
  logic [63:0]       wbuf;
  logic [63:0]       ext_data;
  logic [63:0]       merged;
  logic              collide, misalign, bad;
  logic              do_ld, do_st_d, do_st_sub;

  // Request decode (only meaningful in ST_IDLE).
  always_comb begin
    collide  = req_ld & req_st;
    eff_addr = req_addr;
`ifdef LSU_ALIGN_CHECK_EN
    misalign = (req_ld | req_st) && ((req_addr[2:0] & low_mask(req_size)) != 3'b000);
`else
    misalign = 1'b0;
    eff_addr[2:0] = req_addr[2:0] & ~low_mask(req_size);
`endif
    bad       = collide | misalign;
    do_ld     = req_ld & ~req_st & ~misalign;
    do_st_d   = req_st & ~req_ld & ~misalign & (req_size == SZ_D);
    do_st_sub = req_st & ~req_ld & ~misalign & (req_size != SZ_D);
  end

  lsu_lane_align u_align (
    .rdata    (mem_rdata),
    .lane     (eff_addr[2:0]),
    .size     (req_size),
    .sext     (req_sext),
    .wdata    (req_wdata),
    .ext_data (ext_data),
    .merged   (merged)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (do_st_sub) state_nx = ST_RMW_WR;
      ST_RMW_WR: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output decode. Strobes are gated with rst_n because the idle state alone
  // would still decode a pending request while reset is held.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    stall     = 1'b0;
    mem_addr  = eff_addr;
    mem_wdata = req_wdata;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          MemRead  = do_ld | do_st_sub;
          MemWrite = do_st_d;
          stall    = do_st_sub;
        end
        ST_RMW_WR: begin
          MemWrite  = 1'b1;
          mem_addr  = abuf;
          mem_wdata = wbuf;
        end
        default: ;
      endcase
    end
  end

  // Load result, RMW buffers and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
      err      <= 1'b0;
      wbuf     <= '0;
      abuf     <= '0;
    end else begin
      ld_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (do_ld) begin
          ld_data  <= ext_data;
          ld_valid <= 1'b1;
        end
        if (do_st_sub) begin
          wbuf <= merged;
          abuf <= eff_addr;
        end
      end
      err <= (ERR_STICKY ? err : 1'b0) | ((state == ST_IDLE) && bad);
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ld, req_st, req_sext;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic        MemRead, MemWrite, stall, ld_valid, err;
  logic [63:0] mem_addr, mem_wdata, ld_data;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.ADDR_W(64), .ERR_STICKY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ld(req_ld), .req_st(req_st), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata(mem_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .err(err)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: 32 dwords, combinational read, write gated by rst_n.
  logic [63:0] mem [0:31];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx;
  logic [63:0] bd_data;
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (rst_n && MemWrite) mem[mem_addr[7:3]] <= mem_wdata;
  end

  // Reference model: a flat little-endian byte array.
  logic [7:0] ref_b [0:255];

  function automatic int unsigned eff(input int unsigned a, input logic [1:0] sz);
    int unsigned n;
    n = 1 << sz;
    return a & ~(n - 1);
  endfunction

  function automatic bit misal(input int unsigned a, input logic [1:0] sz);
`ifdef LSU_ALIGN_CHECK_EN
    return (a % (1 << sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_load(input int unsigned a, input logic [1:0] sz, input logic sx);
    logic [63:0] v;
    int unsigned n, b;
    n = 1 << sz;
    b = eff(a, sz);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) v[8*i +: 8] = ref_b[b + i];
      else       v[8*i +: 8] = (sx && ref_b[b + n - 1][7]) ? 8'hFF : 8'h00;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_word(input int unsigned idx);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[idx*8 + i];
    return v;
  endfunction

  task automatic ref_store(input int unsigned a, input logic [1:0] sz, input logic [63:0] wd);
    int unsigned n, b;
    n = 1 << sz;
    b = eff(a, sz);
    for (int i = 0; i < 8; i++) if (i < n) ref_b[b + i] = wd[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int unsigned idx, input logic [63:0] d);
    bd_we = 1'b1; bd_idx = idx[4:0]; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    for (int i = 0; i < 8; i++) ref_b[idx*8 + i] = d[8*i +: 8];
  endtask

  task automatic idle_in();
    req_ld = 1'b0; req_st = 1'b0; req_size = 2'b00; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0;
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [7:0]  addr;
    logic [63:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_rd;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  int unsigned op, a;
  logic [1:0]  sz;
  logic        sx, is_ld, is_st, is_sub, bad;
  logic [63:0] wd, exp_v;

  initial begin
    // ld, st, size, sext, addr, exp_data, exp_valid, exp_err, exp_rd
    vt[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h13, 64'h0000000000000055, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 2'b01, 1'b1, 8'h1E, 64'hFFFFFFFFFFFF8899, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 2'b01, 1'b0, 8'h1E, 64'h0000000000008899, 1'b1, 1'b0, 1'b1};
`ifdef LSU_ALIGN_CHECK_EN
    vt[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 8'h13, 64'h0, 1'b0, 1'b1, 1'b0};
`else
    vt[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 8'h13, 64'h0000000000005566, 1'b1, 1'b0, 1'b1};
`endif
    vt[4] = '{1'b1, 1'b1, 2'b11, 1'b0, 8'h10, 64'h0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 2'b10, 1'b1, 8'h1C, 64'hFFFFFFFF8899AABB, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 2'b11, 1'b0, 8'h10, 64'h1122334455667788, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 2'b00, 1'b1, 8'h18, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 64'h0000000055667788, 1'b1, 1'b0, 1'b1};

    idle_in();
    // Reset: strobes must stay low even with a request pending.
    repeat (2) @(posedge clk);
    #1;
    req_ld = 1'b1; req_size = 2'b11; req_addr = 64'h10;
    #1;
    chk("rst_memread", MemRead, 1'b0);
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_data", ld_data, 64'h0);
    chk("rst_err", err, 1'b0);
    idle_in();

    for (int i = 0; i < 32; i++) poke(i, {$urandom, $urandom});
    poke(2, 64'h1122334455667788);
    poke(3, 64'h8899AABBCCDDEEFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed load vectors
    for (int i = 0; i < NV; i++) begin
      req_ld = vt[i].ld; req_st = vt[i].st; req_size = vt[i].size;
      req_sext = vt[i].sext; req_addr = 64'(vt[i].addr);
      #1;
      chk($sformatf("vec%0d_memread", i), MemRead, vt[i].exp_rd);
      chk($sformatf("vec%0d_memwrite", i), MemWrite, 1'b0);
      chk($sformatf("vec%0d_stall", i), stall, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), ld_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
      if (vt[i].exp_valid) chk($sformatf("vec%0d_data", i), ld_data, vt[i].exp_data);
      idle_in();
    end

    // STURB read-modify-write
    req_st = 1'b1; req_size = 2'b00; req_addr = 64'h11; req_wdata = 64'hAB;
    #1;
    chk("sturb_c0_stall", stall, 1'b1);
    chk("sturb_c0_memread", MemRead, 1'b1);
    chk("sturb_c0_memwrite", MemWrite, 1'b0);
    @(posedge clk); #1;
    chk("sturb_c1_memwrite", MemWrite, 1'b1);
    chk("sturb_c1_memread", MemRead, 1'b0);
    chk("sturb_c1_stall", stall, 1'b0);
    chk("sturb_c1_wdata", mem_wdata, 64'h112233445566AB88);
    chk("sturb_c1_addr", mem_addr[7:3], 64'h2);
    @(posedge clk); #1;
    idle_in();
    ref_store(32'h11, 2'b00, 64'hAB);
    chk("sturb_mem", mem[2], 64'h112233445566AB88);
    req_ld = 1'b1; req_size = 2'b11; req_addr = 64'h10;
    @(posedge clk); #1;
    chk("sturb_readback", ld_data, 64'h112233445566AB88);
    idle_in();

    // STUR dword followed back-to-back by a load of the same address
    req_st = 1'b1; req_size = 2'b11; req_addr = 64'h20; req_wdata = 64'hDEADBEEFCAFEF00D;
    #1;
    chk("stur_memwrite", MemWrite, 1'b1);
    chk("stur_stall", stall, 1'b0);
    chk("stur_wdata", mem_wdata, 64'hDEADBEEFCAFEF00D);
    @(posedge clk); #1;
    ref_store(32'h20, 2'b11, 64'hDEADBEEFCAFEF00D);
    idle_in();
    req_ld = 1'b1; req_size = 2'b11; req_addr = 64'h20;
    #1;
    chk("stur_ld_memread", MemRead, 1'b1);
    @(posedge clk); #1;
    chk("stur_ld_valid", ld_valid, 1'b1);
    chk("stur_ld_data", ld_data, 64'hDEADBEEFCAFEF00D);
    idle_in();

    // Reset asserted during the RMW write cycle
    poke(2, 64'h1122334455667788);
    req_st = 1'b1; req_size = 2'b00; req_addr = 64'h11; req_wdata = 64'hAB;
    @(posedge clk); #1;
    chk("rstrmw_memwrite_pre", MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstrmw_memwrite", MemWrite, 1'b0);
    chk("rstrmw_memread", MemRead, 1'b0);
    chk("rstrmw_stall", stall, 1'b0);
    chk("rstrmw_ld_data", ld_data, 64'h0);
    chk("rstrmw_ld_valid", ld_valid, 1'b0);
    chk("rstrmw_err", err, 1'b0);
    @(posedge clk); #1;
    idle_in();
    rst_n = 1'b1;
    chk("rstrmw_mem", mem[2], 64'h1122334455667788);
    @(posedge clk); #1;
    req_ld = 1'b1; req_size = 2'b00; req_addr = 64'h13;
    @(posedge clk); #1;
    chk("rstrmw_after_ld", ld_data, 64'h55);
    chk("rstrmw_after_valid", ld_valid, 1'b1);
    idle_in();

    // Randomized traffic against the byte-array model
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 255);
      wd = {$urandom, $urandom};
      is_ld = 1'b0; is_st = 1'b0;
      if (op <= 3) is_ld = 1'b1;
      else if (op <= 5) begin is_st = 1'b1; sz = 2'b11; end
      else if (op <= 8) begin is_st = 1'b1; sz = 2'($urandom_range(0, 2)); end
      else if ($urandom_range(0, 1) == 1) begin is_ld = 1'b1; is_st = 1'b1; end
      is_sub = is_st && !is_ld && (sz != 2'b11);
      bad = (is_ld && is_st) || ((is_ld || is_st) && misal(a, sz));
      exp_v = exp_load(a, sz, sx);
      req_ld = is_ld; req_st = is_st; req_size = sz; req_sext = sx;
      req_addr = 64'(a); req_wdata = wd;
      #1;
      chk("rnd_memread", MemRead, !bad && ((is_ld && !is_st) || is_sub));
      chk("rnd_memwrite", MemWrite, !bad && is_st && !is_ld && !is_sub);
      chk("rnd_stall", stall, !bad && is_sub);
      @(posedge clk); #1;
      if (is_st && !is_ld && !bad) ref_store(a, sz, wd);
      if (is_sub && !bad) begin
        chk("rnd_rmw_memwrite", MemWrite, 1'b1);
        chk("rnd_rmw_wdata", mem_wdata, ref_word(eff(a, sz) / 8));
        @(posedge clk); #1;
      end
      chk("rnd_valid", ld_valid, is_ld && !is_st && !bad);
      chk("rnd_err", err, bad);
      if (is_ld && !is_st && !bad) chk("rnd_ld_data", ld_data, exp_v);
      idle_in();
    end

    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
